// File: rtl/hs32_sram_ctl.sv
// hs32_sram_ctl: turns single hs32 core memory requests (word or byte) into per-bank byte beats
// for the dual-bank byte-wide SRAM wrapper, then assembles read data and pulses o_done once per
// request. Banks interleave on byte address bit 0; a word takes two beats with both banks active.
// Optional build macro HS32_SRAM_CTL_FAULT_EN: reject misaligned word accesses and accesses
// outside the 2 KiB window at BASE_ADDR. Without it the upper address bits alias and word
// accesses are forced to a 4-byte boundary.
module hs32_sram_ctl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    output logic        o_rdy,
    input  logic        i_rw,
    input  logic        i_size,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_dtw,
    output logic        o_done,
    output logic [31:0] o_dtr,
    output logic        o_fault,
    output logic [1:0]  mem_we_n,
    output logic [9:0]  mem_addr0,
    output logic [9:0]  mem_addr1,
    output logic [7:0]  mem_dtw0,
    output logic [7:0]  mem_dtw1,
    output logic [3:0]  mem_mask0,
    output logic [3:0]  mem_mask1,
    input  logic [7:0]  mem_dtr0,
    input  logic [7:0]  mem_dtr1
);

`ifdef HS32_SRAM_CTL_FAULT_EN
    typedef enum logic [2:0] {StIdle, StB0, StB1, StResp, StFlt} state_e;
`else
    typedef enum logic [1:0] {StIdle, StB0, StB1, StResp} state_e;
`endif

    state_e      state_q, state_d;
    logic [10:0] addr_q;
    logic [15:0] dtw_hi_q;
    logic        rw_q;
    logic        size_q;
    logic [31:0] dtr_q, dtr_d;
    logic [31:0] rsp_dtr;

    logic [1:0]  we_n_d;
    logic [9:0]  addr0_d, addr1_d;
    logic [7:0]  dtw0_d, dtw1_d;
    logic [3:0]  mask0_d, mask1_d;

    logic        accept;
    logic        beat_go;
    logic [10:0] acc_addr;
    logic [9:0]  acc_baddr;
    logic [9:0]  b1_baddr;

    function automatic logic [3:0] lane_mask(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

    assign o_rdy     = (state_q == StIdle);
    assign accept    = i_req & o_rdy;
    // Word accesses always start on a 4-byte boundary inside the bank pair.
    assign acc_addr  = i_size ? {i_addr[10:2], 2'b00} : i_addr[10:0];
    assign acc_baddr = acc_addr[10:1];
    assign b1_baddr  = addr_q[10:1] + 10'd1;

`ifdef HS32_SRAM_CTL_FAULT_EN
    logic reject;
    logic fault_q;

    assign reject  = (i_size & (i_addr[1:0] != 2'b00)) | (i_addr[31:11] != BASE_ADDR[31:11]);
    assign beat_go = accept & ~reject;
    assign o_done  = (state_q == StResp) | (state_q == StFlt);
    assign o_fault = fault_q;

    // Fault flag: cleared on every accept, set when the accepted request is rejected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (accept) begin
            fault_q <= reject;
        end
    end
`else
    // Upper address bits alias in this build.
    logic unused_addr_hi;

    assign unused_addr_hi = ^{i_addr[31:11], BASE_ADDR};
    assign beat_go        = accept;
    assign o_done         = (state_q == StResp);
    assign o_fault        = 1'b0;
`endif

    // Latch the request so the second beat and read assembly can use it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            dtw_hi_q <= '0;
            rw_q     <= 1'b0;
            size_q   <= 1'b0;
        end else if (accept) begin
            addr_q   <= acc_addr;
            dtw_hi_q <= i_dtw[31:16];
            rw_q     <= i_rw;
            size_q   <= i_size;
        end
    end

    // Next state and the registered SRAM beat for the upcoming cycle.
    always_comb begin
        state_d = state_q;
        we_n_d  = 2'b11;
        mask0_d = 4'h0;
        mask1_d = 4'h0;
        addr0_d = mem_addr0;
        addr1_d = mem_addr1;
        dtw0_d  = mem_dtw0;
        dtw1_d  = mem_dtw1;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
`ifdef HS32_SRAM_CTL_FAULT_EN
                    state_d = reject ? StFlt : StB0;
`else
                    state_d = StB0;
`endif
                end
                if (beat_go) begin
                    if (i_size) begin
                        addr0_d = acc_baddr;
                        addr1_d = acc_baddr;
                        dtw0_d  = i_dtw[7:0];
                        dtw1_d  = i_dtw[15:8];
                        mask0_d = lane_mask(acc_baddr[1:0]);
                        mask1_d = lane_mask(acc_baddr[1:0]);
                        we_n_d  = {~i_rw, ~i_rw};
                    end else if (acc_addr[0]) begin
                        addr1_d = acc_baddr;
                        dtw1_d  = i_dtw[7:0];
                        mask1_d = lane_mask(acc_baddr[1:0]);
                        we_n_d  = {~i_rw, 1'b1};
                    end else begin
                        addr0_d = acc_baddr;
                        dtw0_d  = i_dtw[7:0];
                        mask0_d = lane_mask(acc_baddr[1:0]);
                        we_n_d  = {1'b1, ~i_rw};
                    end
                end
            end
            StB0: begin
                if (size_q) begin
                    state_d = StB1;
                    addr0_d = b1_baddr;
                    addr1_d = b1_baddr;
                    dtw0_d  = dtw_hi_q[7:0];
                    dtw1_d  = dtw_hi_q[15:8];
                    mask0_d = lane_mask(b1_baddr[1:0]);
                    mask1_d = lane_mask(b1_baddr[1:0]);
                    we_n_d  = {~rw_q, ~rw_q};
                end else begin
                    state_d = StResp;
                end
            end
            StB1:   state_d = StResp;
            StResp: state_d = StIdle;
`ifdef HS32_SRAM_CTL_FAULT_EN
            StFlt:  state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase
    end

    // State and SRAM-facing registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            mem_we_n  <= 2'b11;
            mem_addr0 <= '0;
            mem_addr1 <= '0;
            mem_dtw0  <= '0;
            mem_dtw1  <= '0;
            mem_mask0 <= '0;
            mem_mask1 <= '0;
        end else begin
            state_q   <= state_d;
            mem_we_n  <= we_n_d;
            mem_addr0 <= addr0_d;
            mem_addr1 <= addr1_d;
            mem_dtw0  <= dtw0_d;
            mem_dtw1  <= dtw1_d;
            mem_mask0 <= mask0_d;
            mem_mask1 <= mask1_d;
        end
    end

    // Read assembly: low half from the first beat, top bytes straight from the SRAM during RESP.
    always_comb begin
        rsp_dtr = dtr_q;
        dtr_d   = dtr_q;
        if (!rw_q) begin
            if (state_q == StB1) begin
                dtr_d[15:0] = {mem_dtr1, mem_dtr0};
            end
            if (state_q == StResp) begin
                if (size_q) begin
                    rsp_dtr = {mem_dtr1, mem_dtr0, dtr_q[15:0]};
                end else begin
                    rsp_dtr = {24'h0, addr_q[0] ? mem_dtr1 : mem_dtr0};
                end
                dtr_d = rsp_dtr;
            end
        end
        o_dtr = rsp_dtr;
    end

    // Read data register, held until overwritten by the next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dtr_q <= '0;
        end else begin
            dtr_q <= dtr_d;
        end
    end

endmodule

// File: tb/tb_hs32_sram_ctl.sv
// Self-checking bench for hs32_sram_ctl: a byte-wide SRAM bank model per bank, a flat
// reference memory, and scoreboard queues of expected beats and completions.
module tb_hs32_sram_ctl;

    localparam logic [31:0] TB_BASE = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic        o_rdy;
    logic        i_rw;
    logic        i_size;
    logic [31:0] i_addr;
    logic [31:0] i_dtw;
    logic        o_done;
    logic [31:0] o_dtr;
    logic        o_fault;
    logic [1:0]  mem_we_n;
    logic [9:0]  mem_addr0, mem_addr1;
    logic [7:0]  mem_dtw0, mem_dtw1;
    logic [3:0]  mem_mask0, mem_mask1;
    logic [7:0]  mem_dtr0, mem_dtr1;

    hs32_sram_ctl #(.BASE_ADDR(TB_BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .o_rdy    (o_rdy),
        .i_rw     (i_rw),
        .i_size   (i_size),
        .i_addr   (i_addr),
        .i_dtw    (i_dtw),
        .o_done   (o_done),
        .o_dtr    (o_dtr),
        .o_fault  (o_fault),
        .mem_we_n (mem_we_n),
        .mem_addr0(mem_addr0),
        .mem_addr1(mem_addr1),
        .mem_dtw0 (mem_dtw0),
        .mem_dtw1 (mem_dtw1),
        .mem_mask0(mem_mask0),
        .mem_mask1(mem_mask1),
        .mem_dtr0 (mem_dtr0),
        .mem_dtr1 (mem_dtr1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM wrapper model: synchronous write, read data valid the cycle after the beat.
    logic [7:0] bank0 [1024];
    logic [7:0] bank1 [1024];

    always @(posedge clk) begin
        if (!mem_we_n[0]) bank0[mem_addr0] <= mem_dtw0;
        else if (mem_mask0 != 4'h0) mem_dtr0 <= bank0[mem_addr0];
        if (!mem_we_n[1]) bank1[mem_addr1] <= mem_dtw1;
        else if (mem_mask1 != 4'h0) mem_dtr1 <= bank1[mem_addr1];
    end

    typedef struct {
        logic [1:0] we_n;
        logic [9:0] a0, a1;
        logic [7:0] d0, d1;
        logic [3:0] m0, m1;
        bit         act0, act1, wr;
    } beat_t;

    typedef struct {
        logic [31:0] dtr;
        logic        fault;
        int          lat;
    } res_t;

    beat_t       beat_q[$];
    res_t        res_q[$];
    logic [7:0]  ref_mem [2048];
    logic [31:0] last_dtr;
    int          checks;
    int          errors;
    int          cyc;
    int          acc_cyc;
    bit          mon_off;

    // Build expected beats and completion for one request, updating the reference memory.
    task automatic push_expect(input logic rw, input logic size, input logic [31:0] addr,
                               input logic [31:0] dtw);
        logic [10:0] a;
        logic [9:0]  ba;
        logic [3:0]  m;
        beat_t       bt;
        res_t        rs;
        bit          rej;
        a = addr[10:0];
        if (size) a[1:0] = 2'b00;
        rej = 1'b0;
`ifdef HS32_SRAM_CTL_FAULT_EN
        rej = (size && addr[1:0] != 2'b00) || (addr[31:11] != TB_BASE[31:11]);
`endif
        rs.fault = rej;
        rs.lat   = rej ? 1 : (size ? 3 : 2);
        rs.dtr   = last_dtr;
        if (!rej) begin
            ba = a[10:1];
            m  = 4'b0001 << ba[1:0];
            bt.wr = rw;
            bt.a0 = ba;
            bt.a1 = ba;
            if (size) begin
                bt.we_n = rw ? 2'b00 : 2'b11;
                bt.act0 = 1'b1;
                bt.act1 = 1'b1;
                bt.d0 = dtw[7:0];
                bt.d1 = dtw[15:8];
                bt.m0 = m;
                bt.m1 = m;
                beat_q.push_back(bt);
                ba = ba + 10'd1;
                m  = 4'b0001 << ba[1:0];
                bt.a0 = ba;
                bt.a1 = ba;
                bt.d0 = dtw[23:16];
                bt.d1 = dtw[31:24];
                bt.m0 = m;
                bt.m1 = m;
                beat_q.push_back(bt);
                if (rw) begin
                    for (int k = 0; k < 4; k++) ref_mem[a + 11'(k)] = dtw[8*k +: 8];
                end else begin
                    rs.dtr = {ref_mem[a + 11'd3], ref_mem[a + 11'd2], ref_mem[a + 11'd1],
                              ref_mem[a]};
                end
            end else begin
                bt.we_n = !rw ? 2'b11 : (a[0] ? 2'b01 : 2'b10);
                bt.act0 = !a[0];
                bt.act1 = a[0];
                bt.d0 = dtw[7:0];
                bt.d1 = dtw[7:0];
                bt.m0 = a[0] ? 4'h0 : m;
                bt.m1 = a[0] ? m : 4'h0;
                beat_q.push_back(bt);
                if (rw) ref_mem[a] = dtw[7:0];
                else rs.dtr = {24'h0, ref_mem[a]};
            end
            if (!rw) last_dtr = rs.dtr;
        end
        res_q.push_back(rs);
    endtask

    // Drive one request; returns how many cycles it waited for o_rdy. Called at posedge+1.
    task automatic do_req(input logic rw, input logic size, input logic [31:0] addr,
                          input logic [31:0] dtw, input bit push, input bit hold,
                          output int waited);
        i_rw   = rw;
        i_size = size;
        i_addr = addr;
        i_dtw  = dtw;
        i_req  = 1'b1;
        waited = 0;
        while (o_rdy !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checks++;
        if (o_rdy !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout addr=%h o_rdy=%b required=1", addr, o_rdy);
        end
        if (push) push_expect(rw, size, addr, dtw);
        @(posedge clk);
        #1;
        if (!hold) i_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        i_req = 1'b0;
        while ((res_q.size() != 0 || o_rdy !== 1'b1) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (res_q.size() != 0) begin
            errors++;
            $display("FAIL done_timeout pending=%0d required=0", res_q.size());
        end
    endtask

    // Monitor: compare every beat and every completion against the scoreboard.
    initial begin
        beat_t b;
        res_t  r;
        cyc = 0;
        acc_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset === 1'b0 && !mon_off) begin
                if (mem_we_n !== 2'b11 || mem_mask0 !== 4'h0 || mem_mask1 !== 4'h0) begin
                    checks++;
                    if (beat_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat we_n=%b m0=%b m1=%b required=idle",
                                 mem_we_n, mem_mask0, mem_mask1);
                    end else begin
                        b = beat_q.pop_front();
                        if ({mem_we_n, mem_mask0, mem_mask1} !== {b.we_n, b.m0, b.m1}) begin
                            errors++;
                            $display("FAIL beat_ctl got=%b_%b_%b required=%b_%b_%b",
                                     mem_we_n, mem_mask0, mem_mask1, b.we_n, b.m0, b.m1);
                        end
                        if (b.act0) begin
                            checks++;
                            if (mem_addr0 !== b.a0 || (b.wr && mem_dtw0 !== b.d0)) begin
                                errors++;
                                $display("FAIL beat_bank0 got=%h/%h required=%h/%h",
                                         mem_addr0, mem_dtw0, b.a0, b.d0);
                            end
                        end
                        if (b.act1) begin
                            checks++;
                            if (mem_addr1 !== b.a1 || (b.wr && mem_dtw1 !== b.d1)) begin
                                errors++;
                                $display("FAIL beat_bank1 got=%h/%h required=%h/%h",
                                         mem_addr1, mem_dtw1, b.a1, b.d1);
                            end
                        end
                    end
                end
                if (o_done === 1'b1) begin
                    checks++;
                    if (res_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done o_done=1 required=0");
                    end else begin
                        r = res_q.pop_front();
                        if (o_dtr !== r.dtr) begin
                            errors++;
                            $display("FAIL done_dtr got=%h required=%h", o_dtr, r.dtr);
                        end
                        checks++;
                        if (o_fault !== r.fault) begin
                            errors++;
                            $display("FAIL done_fault got=%b required=%b", o_fault, r.fault);
                        end
                        checks++;
                        if (cyc - acc_cyc != r.lat) begin
                            errors++;
                            $display("FAIL done_latency got=%0d required=%0d",
                                     cyc - acc_cyc, r.lat);
                        end
                        checks++;
                        if (beat_q.size() != 0) begin
                            errors++;
                            $display("FAIL missing_beat pending=%0d required=0", beat_q.size());
                        end
                    end
                end
                if (i_req === 1'b1 && o_rdy === 1'b1) acc_cyc = cyc;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_rdy, o_done, o_fault} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags got=%b required=100", {o_rdy, o_done, o_fault});
        end
        checks++;
        if (o_dtr !== 32'h0) begin
            errors++;
            $display("FAIL reset_dtr got=%h required=0", o_dtr);
        end
        checks++;
        if ({mem_we_n, mem_mask0, mem_mask1} !== 10'b11_0000_0000) begin
            errors++;
            $display("FAIL reset_ctl got=%b required=1100000000",
                     {mem_we_n, mem_mask0, mem_mask1});
        end
        checks++;
        if ({mem_addr0, mem_addr1, mem_dtw0, mem_dtw1} !== 36'h0) begin
            errors++;
            $display("FAIL reset_bus got=%h required=0",
                     {mem_addr0, mem_addr1, mem_dtw0, mem_dtw1});
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_word();
        int w;
        do_req(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, w);
        wait_idle();
        do_req(1'b0, 1'b1, 32'h0000_0010, 32'h0, 1'b1, 1'b0, w);
        wait_idle();
        do_req(1'b1, 1'b1, 32'h0000_0024, 32'h0BAD_F00D, 1'b1, 1'b0, w);
        wait_idle();
        do_req(0, 1'b1, 32'h0000_0024, 32'h0, 1'b1, 1'b0, w);
        wait_idle();
    endtask

    task automatic test_byte();
        int w;
        do_req(1'b1, 1'b0, 32'h0000_0123, 32'hFFFF_FF5A, 1'b1, 1'b0, w);
        wait_idle();
        do_req(1'b0, 1'b0, 32'h0000_0123, 32'h0, 1'b1, 1'b0, w);
        wait_idle();
        do_req(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 1'b0, w);
        wait_idle();
        do_req(1'b0, 1'b0, 32'h0000_0013, 32'h0, 1'b1, 1'b0, w);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int w;
        do_req(1'b0, 1'b1, 32'h0000_0010, 32'h0, 1'b1, 1'b1, w);
        do_req(1'b0, 1'b0, 32'h0000_0123, 32'h0, 1'b1, 1'b1, w);
        checks++;
        if (w != 3) begin
            errors++;
            $display("FAIL b2b_word_wait got=%0d required=3", w);
        end
        do_req(1'b1, 1'b1, 32'h0000_0040, 32'h1357_9BDF, 1'b1, 1'b0, w);
        checks++;
        if (w != 2) begin
            errors++;
            $display("FAIL b2b_byte_wait got=%0d required=2", w);
        end
        wait_idle();
    endtask

    task automatic test_wrap();
        int w;
        do_req(1'b1, 1'b1, 32'h0000_07FC, 32'hA1B2_C3D4, 1'b1, 1'b0, w);
        wait_idle();
        do_req(1'b0, 1'b1, 32'h0000_07FC, 32'h0, 1'b1, 1'b0, w);
        wait_idle();
        do_req(1'b1, 1'b1, 32'h0000_07FE, 32'h5566_7788, 1'b1, 1'b0, w);
        wait_idle();
        do_req(1'b0, 1'b1, 32'h0000_07FC, 32'h0, 1'b1, 1'b0, w);
        wait_idle();
    endtask

`ifdef HS32_SRAM_CTL_FAULT_EN
    task automatic test_fault();
        int w;
        do_req(1'b0, 1'b1, 32'h0000_0002, 32'h0, 1'b1, 1'b0, w);
        wait_idle();
        do_req(1'b0, 1'b0, 32'h0000_0800, 32'h0, 1'b1, 1'b0, w);
        wait_idle();
        do_req(1'b0, 1'b1, 32'h0000_0010, 32'h0, 1'b1, 1'b0, w);
        wait_idle();
    endtask
`else
    task automatic test_alias();
        int w;
        do_req(1'b1, 1'b0, 32'h0000_0800, 32'h0000_0077, 1'b1, 1'b0, w);
        wait_idle();
        do_req(1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 1'b0, w);
        wait_idle();
        do_req(1'b0, 1'b1, 32'h0000_0012, 32'h0, 1'b1, 1'b0, w);
        wait_idle();
    endtask
`endif

    task automatic test_reset_abort();
        int w;
        mon_off = 1'b1;
        do_req(1'b1, 1'b1, 32'h0000_0010, 32'h1122_3344, 1'b0, 1'b0, w);
        @(posedge clk);
        #1;
        checks++;
        if (mem_we_n !== 2'b00) begin
            errors++;
            $display("FAIL abort_in_b1 we_n=%b required=00", mem_we_n);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({o_rdy, o_done, o_fault, mem_we_n, mem_mask0, mem_mask1} !== 13'b100_11_0000_0000) begin
            errors++;
            $display("FAIL abort_ctl got=%b required=1001100000000",
                     {o_rdy, o_done, o_fault, mem_we_n, mem_mask0, mem_mask1});
        end
        checks++;
        if ({o_dtr, mem_addr0, mem_addr1, mem_dtw0, mem_dtw1} !== 68'h0) begin
            errors++;
            $display("FAIL abort_bus got=%h required=0",
                     {o_dtr, mem_addr0, mem_addr1, mem_dtw0, mem_dtw1});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        // Only the first beat reached the SRAM.
        ref_mem[11'h010] = 8'h44;
        ref_mem[11'h011] = 8'h33;
        last_dtr = 32'h0;
        beat_q.delete();
        res_q.delete();
        @(posedge clk);
        #1;
        mon_off = 1'b0;
        do_req(1'b0, 1'b1, 32'h0000_0010, 32'h0, 1'b1, 1'b0, w);
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        reset    = 1'b1;
        i_req    = 1'b0;
        i_rw     = 1'b0;
        i_size   = 1'b0;
        i_addr   = 32'h0;
        i_dtw    = 32'h0;
        mon_off  = 1'b0;
        checks   = 0;
        errors   = 0;
        last_dtr = 32'h0;
        for (int k = 0; k < 2048; k++) ref_mem[k] = 8'h00;
        test_reset();
        test_word();
        test_byte();
        test_back_to_back();
        test_wrap();
`ifdef HS32_SRAM_CTL_FAULT_EN
        test_fault();
`else
        test_alias();
`endif
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hs32_sram_ctl.md
Name: hs32_sram_ctl

Overview:
- Sequencer directly upstream of the dual-bank byte-wide SRAM wrapper; converts single 32-bit/8-bit core memory requests into per-bank byte beats.
- Banks interleaved on byte address bit 0; a word access takes two beats, with both banks active in each beat.
- Assembles read bytes after the 1-cycle SRAM read latency and returns one completion pulse per request; sits between the hs32 core bus and the SRAM wrapper.

Parameters:
- BASE_ADDR, 32'h0000_0000, region base; bits [31:11] decode a 2 KiB window.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- i_req  input  1  request valid
- o_rdy  output  1  ready to accept a request
- i_rw  input  1  1 = write, 0 = read
- i_size  input  1  1 = word (4 bytes), 0 = byte
- i_addr  input  32  byte address
- i_dtw  input  32  write data, little-endian; byte writes use [7:0]
- o_done  output  1  one-cycle completion pulse
- o_dtr  output  32  read data; valid while o_done=1
- o_fault  output  1  request rejected; valid while o_done=1
- mem_we_n  output  2  per-bank write enable, active low
- mem_addr0, mem_addr1  output  10  per-bank byte address
- mem_dtw0, mem_dtw1  output  8  per-bank write byte
- mem_mask0, mem_mask1  output  4  per-bank one-hot lane mask
- mem_dtr0, mem_dtr1  input  8  per-bank read byte, valid 1 cycle after its beat

Behaviour:
- Reset values:
  - FSM in IDLE, o_rdy=1, o_done=0, o_dtr=0, o_fault=0.
  - mem_we_n=2'b11, mem_addr*=0, mem_dtw*=0, mem_mask*=0.
- Accept condition: i_req & o_rdy on a clock edge. Address, data, rw and size are registered at that edge. o_rdy=1 only in IDLE.
- Address mapping for byte address A = i_addr[10:0]:
  - bank = A[0]; bank address = A[10:1].
  - Lane mask = 1 << bank_address[1:0].
- States:
  - IDLE -> B0 on accept.
  - B0 -> B1 if word, -> RESP if byte.
  - B1 -> RESP.
  - RESP -> IDLE.
  - FLT -> IDLE (only reachable with the optional feature enabled).
- B0, word access:
  - Both banks active; mem_addr0 = mem_addr1 = A[10:1].
  - mem_dtw0 = dtw[7:0], mem_dtw1 = dtw[15:8].
- B1, word access:
  - Both banks at A[10:1]+1 (10-bit add, wraps).
  - mem_dtw0 = dtw[23:16], mem_dtw1 = dtw[31:24].
- B0, byte access: only bank A[0] is active, with dtw[7:0].
- Inactive bank in any cycle: we_n=1, mask=0, address held.
- Writes: mem_we_n low for the active bank(s) only during B0/B1. Reads keep we_n high and drive masks the same way.
- Read capture:
  - B1 captures the bank bytes from B0 into o_dtr[15:0].
  - RESP captures the bank bytes from B1 into o_dtr[31:16].
  - Byte read: RESP captures the selected bank byte into o_dtr[7:0], and o_dtr[31:8]=0.
- o_done=1 in RESP. o_dtr is held until the next accept; o_fault is cleared on accept.
- Latency, accept edge to o_done high: word = 3 cycles, byte = 2 cycles. Back-to-back throughput: word every 4 cycles, byte every 3 cycles.
- Writes also pulse o_done; o_dtr is unchanged on writes.
- Reset mid-operation aborts immediately and returns to reset values. A word write may be left half-written; this is documented, not an error.

Optional Feature:
- Macro: HS32_SRAM_CTL_FAULT_EN.
- Enabled:
  - A word access with i_addr[1:0]!=0 is rejected.
  - Any access with i_addr[31:11] != BASE_ADDR[31:11] is rejected.
  - Rejection path: accept -> FLT. No SRAM beat is issued (we_n stays 11, masks stay 0). o_done=1 and o_fault=1 are asserted 1 cycle after accept, and o_dtr is unchanged.
- Disabled:
  - i_addr[31:11] is ignored (aliasing).
  - Word accesses force A[1:0]=0.
  - o_fault is tied 0 and no FLT state exists.

Test Plan:
- Word write 0xDEADBEEF at 0x010, then word read at 0x010:
  - Write beats: B0 addr0=addr1=0x008 with bytes EF/BE, masks 0001; B1 addr 0x009 with bytes AD/DE, masks 0010.
  - Read: o_dtr=0xDEADBEEF, with o_done 3 cycles after accept.
- Byte write 0x5A at 0x123:
  - Only bank1 is active, at addr 0x091 with mask 0010; mem_we_n=2'b01.
  - Byte read at 0x123 returns o_dtr=0x0000005A at 2 cycles.
- Back-to-back: i_req held high with a word read then a byte read.
  - o_rdy is low for B0..RESP.
  - The second accept happens the cycle after RESP; both results are correct.
- Wrap: word write at 0x7FC reaches bank addresses 0x3FE and then 0x3FF. Word write at 0x7FE (FAULT_EN off, forced to 0x7FC) writes the same locations.
- Reset asserted during B1 of a word write:
  - Outputs go to reset values asynchronously and the FSM goes to IDLE.
  - Reading 0x010 afterwards shows the low half updated and the high half old.
- With HS32_SRAM_CTL_FAULT_EN, word read at 0x002 and byte read at 0x0000_0800:
  - o_fault=1 with o_done 1 cycle after accept.
  - mem_we_n stays 11 and masks stay 0 throughout.
